// File: rtl/muldiv_unit.sv
// Radix-2 iterative multiply/divide unit holding the architectural HI/LO registers.
// One product/quotient bit per cycle in CALC, then a single sign-fix cycle that commits HI/LO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_dat,
    input  logic [WIDTH-1:0] rt_dat,
    input  logic             abort,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdat,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               divz_q, divz_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   low_q, low_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               is_signed;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign is_signed = ~op[0];
    assign rs_neg    = is_signed & rs_dat[WIDTH-1];
    assign rt_neg    = is_signed & rt_dat[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_dat : rs_dat;
    assign rt_mag    = rt_neg ? -rt_dat : rt_dat;

    // Multiply: acc holds the running upper half, low shifts multiplier out and product in.
    assign sum      = {1'b0, acc_q[WIDTH-1:0]} + {1'b0, opb_q};
    // Divide: acc is the partial remainder, low shifts dividend out and quotient in.
    assign shifted  = {acc_q[WIDTH-1:0], low_q[WIDTH-1]};
    assign trial    = {1'b0, shifted} - {2'b00, opb_q};

    assign prod     = {acc_q[WIDTH-1:0], low_q};
    assign prod_fix = neg_q ? -prod : prod;
    // With a zero divisor the remainder magnitude equals the dividend magnitude, so
    // re-applying the dividend sign returns rs unchanged.
    assign quot_fix = divz_q ? {WIDTH{1'b1}} : (neg_q ? -low_q : low_q);
    assign rem_fix  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        divz_d   = divz_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        low_d    = low_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    is_div_d = op[1];
                    acc_d    = '0;
                    neg_d    = rs_neg ^ rt_neg;
                    if (op[1]) begin
                        low_d  = rs_mag;
                        opb_d  = rt_mag;
                        rneg_d = rs_neg;
                        divz_d = (rt_dat == '0);
                    end else begin
                        low_d  = rt_mag;
                        opb_d  = rs_mag;
                        rneg_d = 1'b0;
                        divz_d = 1'b0;
                    end
                end else if (!start) begin
                    if (mthi) hi_d = wdat;
                    if (mtlo) lo_d = wdat;
                end
            end
            CALC: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (is_div_q) begin
                        if (!trial[WIDTH+1]) begin
                            acc_d = trial[WIDTH:0];
                            low_d = {low_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = shifted;
                            low_d = {low_q[WIDTH-2:0], 1'b0};
                        end
                    end else if (low_q[0]) begin
                        acc_d = {1'b0, sum[WIDTH:1]};
                        low_d = {sum[0], low_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[WIDTH:1]};
                        low_d = {acc_q[0], low_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!abort) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            divz_q   <= 1'b0;
            opb_q    <= '0;
            acc_q    <= '0;
            low_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            divz_q   <= divz_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, boundaries, abort, mthi/mtlo, reset.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] rs_dat = '0;
    logic [W-1:0] rt_dat = '0;
    logic         abort = 1'b0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] wdat = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .start  (start),
        .op     (op),
        .rs_dat (rs_dat),
        .rt_dat (rt_dat),
        .abort  (abort),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdat   (wdat),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Launch at a negedge, hold start for one edge, then count busy cycles up to done.
    // inj > 0 re-asserts start (MULTU 9*9) at that busy cycle; it must be ignored.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inj,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        int cycles;
        @(negedge CLK);
        start = 1'b1; op = o; rs_dat = a; rt_dat = b;
        @(negedge CLK);
        start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 60) begin
            cycles++;
            if (cycles == inj) begin
                start = 1'b1; op = OP_MULTU; rs_dat = 32'd9; rt_dat = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge CLK);
        end
        start = 1'b0;
        check({tag, " latency"}, W'(cycles), 32'd33);
        check({tag, " done"}, W'(done), 32'd1);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
        @(negedge CLK);
        check({tag, " done drop"}, W'(done), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", W'(busy), 32'd0);
        check("reset done", W'(done), 32'd0);
        RST = 1'b0;

        run_op("MULT -3*5", OP_MULT, 32'hFFFFFFFD, 32'd5, 0, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("MULTU max*max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 32'h00000001);
        run_op("MULTU 2^16*2^16", OP_MULTU, 32'h00010000, 32'h00010000, 0, 32'h1, 32'h0);
        run_op("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("DIVU 7/2", OP_DIVU, 32'd7, 32'd2, 0, 32'h1, 32'h3);
        run_op("DIV ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0, 32'h80000000);
        run_op("DIVU 0x1234/0", OP_DIVU, 32'h1234, 32'h0, 10, 32'h1234, 32'hFFFFFFFF);
        run_op("DIV -5/0", OP_DIV, 32'hFFFFFFFB, 32'h0, 0, 32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("MULT -3*5 again", OP_MULT, 32'hFFFFFFFD, 32'd5, 0, 32'hFFFFFFFF, 32'hFFFFFFF1);

        // Abort at busy cycle 5 of DIVU 100/7.
        @(negedge CLK);
        start = 1'b1; op = OP_DIVU; rs_dat = 32'd100; rt_dat = 32'd7;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        check("abort pre busy", W'(busy), 32'd1);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("abort busy", W'(busy), 32'd0);
        check("abort done", W'(done), 32'd0);
        check("abort hi", hi, 32'hFFFFFFFF);
        check("abort lo", lo, 32'hFFFFFFF1);
        @(negedge CLK);
        check("abort no late done", W'(done), 32'd0);

        // abort together with start in IDLE launches nothing.
        start = 1'b1; abort = 1'b1; op = OP_MULTU; rs_dat = 32'd2; rt_dat = 32'd2;
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        check("abort+start busy", W'(busy), 32'd0);

        mthi = 1'b1; wdat = 32'hAAAA5555;
        @(negedge CLK);
        mthi = 1'b0;
        check("mthi hi", hi, 32'hAAAA5555);
        check("mthi lo kept", lo, 32'hFFFFFFF1);

        // MULTU 3*4 with an mtlo while busy, then async reset at busy cycle 12.
        start = 1'b1; op = OP_MULTU; rs_dat = 32'd3; rt_dat = 32'd4;
        @(negedge CLK);
        start = 1'b0;
        repeat (2) @(negedge CLK);
        mtlo = 1'b1; wdat = 32'h5A5A5A5A;
        @(negedge CLK);
        mtlo = 1'b0;
        check("mtlo busy lo", lo, 32'hFFFFFFF1);
        repeat (8) @(negedge CLK);
        check("pre-rst busy", W'(busy), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("rst hi", hi, 32'h0);
        check("rst lo", lo, 32'h0);
        check("rst busy", W'(busy), 32'd0);
        check("rst done", W'(done), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        run_op("MULTU 3*4", OP_MULTU, 32'd3, 32'd4, 0, 32'h0, 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath, directly downstream of the register file read ports.
- Consumes the rs/rt operands (register file rdat1/rdat2) for MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers, which feed MFHI/MFLO writeback into the register file.
- Radix-2, one bit per cycle; the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  launch the operation selected by op; accepted only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- rs_dat  in  WIDTH  multiplicand/dividend; sampled with start.
- rt_dat  in  WIDTH  multiplier/divisor; sampled with start.
- abort  in  1  squash the in-flight operation.
- mthi  in  1  write wdat into HI.
- mtlo  in  1  write wdat into LO.
- wdat  in  WIDTH  data for mthi/mtlo.
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse after HI/LO is updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state IDLE, hi=0, lo=0, busy=0, done=0, iteration counter=0. RST mid-operation discards it; no partial HI/LO write.
- States: IDLE, CALC, FIX. busy=1 in CALC or FIX, 0 otherwise. All outputs are registered.
- IDLE + start at edge E0:
  - Latch op and the operand magnitudes (absolute values for signed ops).
  - Latch the result-sign flags.
  - Clear the accumulator and counter; go to CALC.
- CALC, each edge:
  - Multiply: shift-add one multiplier bit.
  - Divide: restoring shift-subtract, one quotient bit.
  - Counter increments; after WIDTH edges (E0+WIDTH) go to FIX.
- FIX, one edge (E0+WIDTH+1):
  - Apply sign correction and write hi/lo.
  - Set done=1 and return to IDLE.
  - New hi/lo values and done=1 are visible after edge E0+WIDTH+1 (33 cycles for WIDTH=32).
  - done drops at the next edge.
- Multiply results: the product is 2*WIDTH bits; hi gets the upper half, lo the lower half.
  - MULT: signed; the product is negated if the operand signs differ.
  - MULTU: unsigned.
- Divide results: lo=quotient, hi=remainder.
  - DIV truncates toward zero: quotient negative iff operand signs differ; remainder takes the dividend's sign.
  - DIVU: unsigned.
- Divide by zero (rt_dat=0), DIV or DIVU: lo={WIDTH{1}}, hi=rs_dat unmodified. Same latency; no exception.
- DIV overflow (rs_dat=0x80000000, rt_dat=0xFFFFFFFF): lo=0x80000000, hi=0.
- start while busy: ignored; no effect on the in-flight operation.
- start in the cycle where done=1: accepted (state is IDLE).
- abort in CALC or FIX: go to IDLE at the next edge.
  - hi/lo keep their previous values; done stays 0.
  - abort together with start in IDLE: abort wins; nothing is launched.
- mthi/mtlo:
  - Honoured only in IDLE without start; write wdat into hi/lo at the edge. Both may be asserted together.
  - Ignored while busy, or when start is asserted in the same cycle (start has priority).
- Operands are captured at start; rs_dat/rt_dat changes during busy have no effect.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFD (-3), rt=5 -> busy for 33 cycles; done pulses once; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then MULTU 0x00010000*0x00010000 -> hi=1, lo=0.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/2 -> lo=3, hi=1. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234 after 33 cycles. A second start at cycle 10 (different operands) is ignored.
- After a MULT giving hi=0xFFFFFFFF, lo=0xFFFFFFF1: start DIVU 100/7, abort at cycle 5 -> busy=0 next cycle, no done pulse, hi/lo unchanged (0xFFFFFFFF/0xFFFFFFF1).
  - Then mthi wdat=0xAAAA5555 in IDLE -> hi=0xAAAA5555 next cycle.
  - Then mtlo while busy -> lo unchanged.
- Start MULTU 3*4, assert RST asynchronously at cycle 12 -> hi=lo=0, busy=0, done=0 immediately. After release, a fresh MULTU 3*4 -> lo=12, hi=0.
